// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, stall, jump/branch redirect.
// Optional performance counters are built when PC_PERF_CNT_EN is defined.
module pc_sequencer #(
  parameter int                 width    = 32,
  parameter logic [width-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [width-1:0]   PCBranch,
  input  logic               PCSrc,
  input  logic [width-1:0]   JumpTarget,
  input  logic               Jump,
  input  logic               Stall,
  input  logic               Halt,
  input  logic               Resume,
  output logic [width-1:0]   PC,
  output logic [width-1:0]   PCPlus1,
  output logic               FetchValid,
  output logic               Redirect,
  output logic               Halted
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0]        BranchCount,
  output logic [31:0]        StallCount
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [width-1:0]   r_pc;
  logic [width-1:0]   w_nextPc;
  logic               r_redirect;
  logic               w_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_redirect <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_pc       <= w_nextPc;
      r_redirect <= w_load;
    end
  end

  // Halt outranks Stall, which outranks Jump, which outranks PCSrc.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_load      = 1'b0;
    case (r_state)
      BOOT: w_nextState = RUN;
      RUN: begin
        if (Halt) begin
          w_nextState = HALT;
        end else if (Stall) begin
          w_nextPc = r_pc;
        end else if (Jump) begin
          w_nextPc = JumpTarget;
          w_load   = 1'b1;
        end else if (PCSrc) begin
          w_nextPc = PCBranch;
          w_load   = 1'b1;
        end else begin
          w_nextPc = PCPlus1;
        end
      end
      HALT: begin
        if (Resume && !Halt) w_nextState = RUN;
      end
      default: w_nextState = BOOT;
    endcase
  end

  always_comb begin
    PC         = r_pc;
    PCPlus1    = r_pc + width'(1);
    FetchValid = (r_state == RUN);
    Halted     = (r_state == HALT);
    Redirect   = r_redirect;
  end

`ifdef PC_PERF_CNT_EN
  logic [31:0] r_branchCount;
  logic [31:0] r_stallCount;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branchCount <= '0;
      r_stallCount  <= '0;
    end else begin
      if (w_load && r_branchCount != 32'hFFFF_FFFF)
        r_branchCount <= r_branchCount + 32'd1;
      if (r_state == RUN && Stall && !Halt && r_stallCount != 32'hFFFF_FFFF)
        r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign BranchCount = r_branchCount;
  assign StallCount  = r_stallCount;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard testbench for pc_sequencer (width=8, RESET_PC=8'h10).
// Define PC_PERF_CNT_EN to also check the performance counters.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] PCBranch, JumpTarget;
  logic       PCSrc, Jump, Stall, Halt, Resume;
  logic [7:0] PC, PCPlus1;
  logic       FetchValid, Redirect, Halted;
`ifdef PC_PERF_CNT_EN
  logic [31:0] BranchCount, StallCount;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [7:0] pc;
    logic       fv;
    logic       rd;
    logic       h;
    string      name;
  } exp_t;

  exp_t expQ[$];

  pc_sequencer #(.width(8), .RESET_PC(8'h10)) dut (
    .clk(clk), .reset(reset),
    .PCBranch(PCBranch), .PCSrc(PCSrc),
    .JumpTarget(JumpTarget), .Jump(Jump),
    .Stall(Stall), .Halt(Halt), .Resume(Resume),
    .PC(PC), .PCPlus1(PCPlus1),
    .FetchValid(FetchValid), .Redirect(Redirect), .Halted(Halted)
`ifdef PC_PERF_CNT_EN
    , .BranchCount(BranchCount), .StallCount(StallCount)
`endif
  );

  always #5 clk = ~clk;

  // Compares all visible outputs against one expected snapshot.
  task automatic checkOutput(input exp_t e);
    logic [7:0] expPlus1;
    expPlus1 = e.pc + 8'd1;
    testsRun++;
    if (PC !== e.pc || PCPlus1 !== expPlus1 || FetchValid !== e.fv ||
        Redirect !== e.rd || Halted !== e.h) begin
      testsFailed++;
      $display("[TB] FAIL %s: got PC=%h PCPlus1=%h FV=%b Rd=%b H=%b, want PC=%h PCPlus1=%h FV=%b Rd=%b H=%b",
               e.name, PC, PCPlus1, FetchValid, Redirect, Halted,
               e.pc, expPlus1, e.fv, e.rd, e.h);
    end
  endtask

  // Called at a negedge: drives inputs for the coming edge, queues the
  // expected post-edge outputs, then moves to the next negedge.
  task automatic applyStimulus(input logic pcSrcIn, input logic [7:0] pcBranchIn,
                               input logic jumpIn, input logic [7:0] jumpTargetIn,
                               input logic stallIn, input logic haltIn, input logic resumeIn,
                               input logic [7:0] expPc, input logic expFv,
                               input logic expRd, input logic expH, input string name);
    exp_t e;
    PCSrc = pcSrcIn; PCBranch = pcBranchIn;
    Jump = jumpIn; JumpTarget = jumpTargetIn;
    Stall = stallIn; Halt = haltIn; Resume = resumeIn;
    e.pc = expPc; e.fv = expFv; e.rd = expRd; e.h = expH; e.name = name;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic [7:0] expPc, input string name);
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0, expPc, 1, 0, 0, name);
  endtask

  task automatic checkNow(input logic [7:0] expPc, input logic expFv,
                          input logic expRd, input logic expH, input string name);
    exp_t e;
    e.pc = expPc; e.fv = expFv; e.rd = expRd; e.h = expH; e.name = name;
    checkOutput(e);
  endtask

`ifdef PC_PERF_CNT_EN
  task automatic checkCounters(input logic [31:0] expBr, input logic [31:0] expSt, input string name);
    testsRun++;
    if (BranchCount !== expBr || StallCount !== expSt) begin
      testsFailed++;
      $display("[TB] FAIL %s: got BranchCount=%0d StallCount=%0d, want BranchCount=%0d StallCount=%0d",
               name, BranchCount, StallCount, expBr, expSt);
    end
  endtask
`endif

  // Monitor: every clocked update is checked against the oldest queued entry.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    PCBranch = '0; JumpTarget = '0;
    PCSrc = 0; Jump = 0; Stall = 0; Halt = 0; Resume = 0;
    #12;
    checkNow(8'h10, 0, 0, 0, "reset_state");
    @(negedge clk);
    reset = 1'b0;
    checkNow(8'h10, 0, 0, 0, "boot_cycle");

    idle(8'h10, "boot_to_run");
    idle(8'h11, "seq_11");
    idle(8'h12, "seq_12");
    applyStimulus(0, 8'h00, 1, 8'h05, 0, 0, 0, 8'h05, 1, 1, 0, "jump_to_5");
    applyStimulus(1, 8'h20, 0, 8'h00, 0, 0, 0, 8'h20, 1, 1, 0, "branch_to_20");
    idle(8'h21, "after_branch");
    applyStimulus(1, 8'h20, 1, 8'h40, 0, 0, 0, 8'h40, 1, 1, 0, "jump_beats_branch");
    applyStimulus(1, 8'h20, 0, 8'h00, 1, 0, 0, 8'h40, 1, 0, 0, "stall_beats_branch");
    applyStimulus(0, 8'h00, 1, 8'hFF, 0, 0, 0, 8'hFF, 1, 1, 0, "jump_to_ff");
    idle(8'h00, "wrap_to_00");
    applyStimulus(0, 8'h00, 1, 8'h07, 0, 0, 0, 8'h07, 1, 1, 0, "jump_to_7");
    applyStimulus(0, 8'h00, 1, 8'h99, 0, 1, 0, 8'h07, 0, 0, 1, "halt_beats_jump");
    for (int i = 0; i < 5; i++)
      applyStimulus(i[0], 8'h33, ~i[0], 8'h55, i[0], 0, 0, 8'h07, 0, 0, 1, "halt_hold");
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 1, 8'h07, 0, 0, 1, "halt_and_resume");
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h07, 1, 0, 0, "resume");
    idle(8'h08, "after_resume");
    applyStimulus(1, 8'h30, 0, 8'h00, 0, 0, 0, 8'h30, 1, 1, 0, "branch_to_30");

    // Async reset in the middle of a redirect cycle.
    PCSrc = 1; PCBranch = 8'h44;
    #2;
    reset = 1'b1;
    #1;
    checkNow(8'h10, 0, 0, 0, "async_reset");
`ifdef PC_PERF_CNT_EN
    checkCounters(32'd0, 32'd0, "counters_after_reset");
`endif
    PCSrc = 0;
    @(negedge clk);
    reset = 1'b0;
    checkNow(8'h10, 0, 0, 0, "boot_after_reset");
    idle(8'h10, "boot_to_run_2");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 8'h77, 0, 8'h00, 1, 0, 0, 8'h10, 1, 0, 0, "stall_count");
    applyStimulus(1, 8'h50, 0, 8'h00, 0, 0, 0, 8'h50, 1, 1, 0, "branch_to_50");
    applyStimulus(0, 8'h00, 1, 8'h60, 0, 0, 0, 8'h60, 1, 1, 0, "jump_to_60");
    idle(8'h61, "seq_61");
`ifdef PC_PERF_CNT_EN
    checkCounters(32'd2, 32'd3, "perf_counters");
`endif

    repeat (3) @(negedge clk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
